// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces launches into a uart_tx transmitter
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_dv,
  input  logic [7:0]    i_wr_byte,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  input  logic          i_tx_active,
  input  logic          i_tx_done,
  output logic          o_tx_dv,
  output logic [7:0]    o_tx_byte,
  output logic          o_overflow,
  input  logic          i_ovf_clr
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_WAIT_CLR  = 2'd3;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          pop;
  logic          wr_accept;
  logic          wr_drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
  always_comb begin
    pop       = (state_q == S_IDLE) && !empty_q && !i_tx_active;
    wr_accept = i_wr_dv && (!full_q || pop);
    wr_drop   = i_wr_dv && full_q && !pop;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_byte_d = tx_byte_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      tx_byte_d = mem_q[rd_ptr_q];
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pop) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (i_tx_done) state_d = S_WAIT_CLR;
      S_WAIT_CLR:  if (!i_tx_done && !i_tx_active) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= i_wr_byte;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      state_q   <= S_IDLE;
      tx_byte_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (wr_drop) begin
      ovf_q <= 1'b1;
    end else if (i_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign o_overflow = ovf_q;
`else
  logic ovf_unused;

  assign ovf_unused = i_ovf_clr ^ wr_drop;
  assign o_overflow = 1'b0;
`endif

  assign o_full    = full_q;
  assign o_empty   = empty_q;
  assign o_count   = count_q;
  assign o_tx_dv   = (state_q == S_LAUNCH);
  assign o_tx_byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TXLEN = 8;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_dv;
  logic [7:0]    wr_byte;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          tx_active;
  logic          tx_done;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          overflow;
  logic          ovf_clr;

  logic          hold_active;
  logic          m_active;
  logic          m_done;
  int            m_busy;

  int            n_cmp = 0;
  int            n_err = 0;
  int            violations = 0;
  logic [7:0]    launched [$];
  logic [7:0]    exp_q [$];
  logic [7:0]    burst [8] = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h3C, 8'hC3};

  assign tx_active = m_active | hold_active;
  assign tx_done   = m_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_dv     (wr_dv),
    .i_wr_byte   (wr_byte),
    .o_full      (full),
    .o_empty     (empty),
    .o_count     (count),
    .i_tx_active (tx_active),
    .i_tx_done   (tx_done),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .o_overflow  (overflow),
    .i_ovf_clr   (ovf_clr)
  );

  // Transmitter stand-in: busy for TXLEN cycles per launch, then a one-cycle done pulse.
  always @(negedge clk) begin
    if (tx_dv && (m_busy > 0 || m_done || m_active)) violations++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_busy   = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (tx_dv) begin
      launched.push_back(tx_byte);
      m_active = 1'b1;
      m_busy   = TXLEN;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_launches(input int n);
    int cyc = 0;
    while (launched.size() < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (TXLEN + 6) @(negedge clk);
    check("launch_count", launched.size(), n);
  endtask

  task automatic check_stream(input string tag);
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
      check(tag, launched[i], exp_q[i]);
    end
    launched.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    wr_dv       = 1'b0;
    wr_byte     = 8'h00;
    ovf_clr     = 1'b0;
    hold_active = 1'b0;
    m_active    = 1'b0;
    m_done      = 1'b0;
    m_busy      = 0;

    repeat (2) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_ovf", overflow, 0);

    // Single byte right after reset release: launch one cycle after the write edge.
    @(negedge clk);
    rst_n   = 1'b1;
    wr_dv   = 1'b1;
    wr_byte = 8'h55;
    @(negedge clk);
    wr_dv = 1'b0;
    check("lat_count_after_write", count, 1);
    check("lat_empty_after_write", empty, 0);
    check("lat_dv_before_pop", tx_dv, 0);
    @(negedge clk);
    check("lat_dv_at_pop", tx_dv, 1);
    check("lat_tx_byte", tx_byte, 8'h55);
    check("lat_empty_after_pop", empty, 1);
    check("lat_count_after_pop", count, 0);
    @(negedge clk);
    check("lat_dv_one_cycle", tx_dv, 0);
    exp_q.push_back(8'h55);
    wait_launches(1);
    check_stream("lat_stream");

    // Burst of eight on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_dv   = 1'b1;
      wr_byte = burst[i];
      exp_q.push_back(burst[i]);
    end
    @(negedge clk);
    wr_dv = 1'b0;
    wait_launches(8);
    check_stream("burst_stream");
    check("burst_violations", violations, 0);
    check("burst_count_end", count, 0);
    check("burst_empty_end", empty, 1);

    // Transmitter held busy: fill past capacity, last two dropped.
    @(negedge clk);
    hold_active = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      wr_dv   = 1'b1;
      wr_byte = 8'(8'h10 + i);
    end
    @(negedge clk);
    wr_dv = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_count", count, DEPTH);
    check("ovf_empty", empty, 0);
    check("ovf_flag", overflow, OVF_EN);
    check("ovf_no_launch", launched.size(), 0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO: write 0xA5 in the same cycle as the first pop.
    @(negedge clk);
    hold_active = 1'b0;
    wr_dv       = 1'b1;
    wr_byte     = 8'hA5;
    @(negedge clk);
    wr_dv = 1'b0;
    check("fullpop_count", count, DEPTH);
    check("fullpop_full", full, 1);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_dv", tx_dv, 1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'hA5);
    wait_launches(DEPTH + 1);
    check_stream("fullpop_stream");
    check("fullpop_count_end", count, 0);
    check("fullpop_empty_end", empty, 1);

    // Reset mid-transfer with five bytes still queued.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_dv   = 1'b1;
      wr_byte = 8'(8'h60 + i);
    end
    @(negedge clk);
    wr_dv = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_queued", count, 5);
    check("midrst_in_flight", launched.size(), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_dv", tx_dv, 0);
    check("midrst_tx_byte", tx_byte, 8'h00);
    check("midrst_ovf", overflow, 0);
    launched.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_launch", launched.size(), 0);
    check("midrst_still_empty", empty, 1);
    @(negedge clk);
    wr_dv   = 1'b1;
    wr_byte = 8'h77;
    @(negedge clk);
    wr_dv = 1'b0;
    check("midrst_first_write", count, 1);
    exp_q.push_back(8'h77);
    wait_launches(1);
    check_stream("midrst_stream");

    // Twenty bytes spaced out so pops interleave and both pointers wrap.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_dv   = 1'b1;
      wr_byte = 8'(i * 13 + 7);
      exp_q.push_back(8'(i * 13 + 7));
      @(negedge clk);
      wr_dv = 1'b0;
      repeat (2) @(negedge clk);
    end
    wait_launches(20);
    check_stream("wrap_stream");
    check("wrap_count_end", count, 0);
    check("wrap_empty_end", empty, 1);
    check("wrap_violations", violations, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, meaning the FIFO byte capacity (power of two, 2..256).
REQ-002 SHALL provide parameter AW, default $clog2(DEPTH), meaning the pointer width.
REQ-003 SHALL provide port i_clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL provide port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port i_wr_dv  input  1  write strobe; one byte per cycle high.
REQ-006 SHALL provide port i_wr_byte  input  8  byte to enqueue.
REQ-007 SHALL provide port o_full  output  1  high when count == DEPTH.
REQ-008 SHALL provide port o_empty  output  1  high when count == 0.
REQ-009 SHALL provide port o_count  output  AW+1  bytes currently stored (not including a byte already launched).
REQ-010 SHALL provide port i_tx_active  input  1  uart_tx o_tx_active.
REQ-011 SHALL provide port i_tx_done  input  1  uart_tx o_tx_done.
REQ-012 SHALL provide port o_tx_dv  output  1  one-cycle launch strobe to uart_tx i_tx_dv.
REQ-013 SHALL provide port o_tx_byte  output  8  byte to uart_tx i_tx_byte; held stable from launch until the next launch.
REQ-014 SHALL provide port o_overflow  output  1  sticky overflow flag.
REQ-015 SHALL provide port i_ovf_clr  input  1  synchronous clear of o_overflow.

Function
REQ-016 SHALL store bytes in a circular buffer with AW-bit read/write pointers wrapping DEPTH-1 -> 0.
REQ-017 SHALL accept a write when i_wr_dv=1 and (o_full=0 or a pop occurs in the same cycle); count unchanged on simultaneous accepted write and pop.
REQ-018 SHALL drop a write when i_wr_dv=1, o_full=1 and no same-cycle pop; storage and pointers unchanged.
REQ-019 SHALL implement launch FSM states IDLE, LAUNCH, WAIT_DONE, WAIT_CLR.
REQ-020 IDLE: when o_empty=0 and i_tx_active=0, pop head byte into o_tx_byte and go to LAUNCH.
REQ-021 LAUNCH: o_tx_dv=1 for exactly this one cycle; next state WAIT_DONE.
REQ-022 WAIT_DONE: stay until i_tx_done=1, then go to WAIT_CLR.
REQ-023 WAIT_CLR: stay until i_tx_done=0 and i_tx_active=0, then go to IDLE.
REQ-024 o_tx_dv SHALL be 0 in every state except LAUNCH.
REQ-025 Latency: byte written on edge E0 into an empty FIFO with FSM in IDLE -> pop on E1, o_tx_dv high between E1 and E2.
REQ-026 Back-to-back bytes: next pop no earlier than the cycle after WAIT_CLR exits; never two launches without an intervening i_tx_done pulse.
REQ-027 o_full, o_empty, o_count SHALL be registered and consistent with pointers in the same cycle.

Reset
REQ-028 i_rst_n=0 SHALL immediately clear pointers, count=0, o_empty=1, o_full=0, o_tx_dv=0, o_tx_byte=8'h00, o_overflow=0, FSM=IDLE.
REQ-029 Reset during LAUNCH/WAIT_DONE/WAIT_CLR SHALL abandon the in-flight byte and discard all stored bytes.
REQ-030 After i_rst_n deasserts, the first write SHALL be accepted on the next rising edge.

Configuration
REQ-031 Macro UART_TX_FIFO_OVF_EN defined: o_overflow sets on any dropped write (REQ-018), holds until i_ovf_clr=1; set wins over clear in the same cycle.
REQ-032 Macro UART_TX_FIFO_OVF_EN undefined: o_overflow tied 0, i_ovf_clr ignored, no overflow register synthesized.

Verification
REQ-033 Write 8'h55 into empty FIFO, uart_tx connected, CLKS_PER_BIT=1042 -> o_tx_dv one cycle after write edge; serial line decodes 0x55; o_empty=1 after pop.
REQ-034 Burst-write 0x55,0xAA,0x00,0xFF,0x0F,0xF0,0x3C,0xC3 on consecutive cycles -> serial output in that order, exactly 8 o_tx_dv pulses, each after prior i_tx_done falls.
REQ-035 Hold i_tx_active=1, write DEPTH+2 bytes -> o_full=1, o_count=16, last 2 dropped, o_overflow=1 (macro on) / 0 (macro off); i_ovf_clr clears it.
REQ-036 Full FIFO with simultaneous write 8'hA5 and pop -> o_count stays 16, 8'hA5 later transmitted last, o_overflow stays 0.
REQ-037 Assert i_rst_n=0 mid-transfer in WAIT_DONE with 5 bytes queued -> all outputs at reset values same cycle, no further o_tx_dv until new write.
REQ-038 Write 20 bytes through DEPTH=16 FIFO with interleaved pops -> pointer wrap, all 20 bytes transmitted in order, count returns to 0.
